reg_ram_host_bridge: RTL and testbench

//  Host-side writer for the dual-port register RAM polled by the register-copy FSM.

---
 rtl/reg_ram_host_bridge.sv | 144 ++++++++++++++
 tb/tb_reg_ram_host_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_ram_host_bridge.sv
// Host-side port-A master for the dual-port register RAM.
// Serialises host register reads/writes and runs the flags commit sequence
// (set bit0, hold for the poller's copy loop, clear) so every commit yields
// exactly one register update on the polling side.
module reg_ram_host_bridge #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int FLAGS_ADDR  = 0,
  parameter int RD_LAT      = 1,
  parameter int COMMIT_HOLD = 16
) (
  input  logic          c,
  input  logic          rst,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  input  logic          commit,
  output logic          commit_busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q
);

  // One counter serves both the read-latency wait and the commit hold.
  localparam int CMAX = (COMMIT_HOLD > RD_LAT) ? COMMIT_HOLD : RD_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [AW-1:0] FLAGS = AW'(FLAGS_ADDR);

  typedef enum logic [2:0] {
    INIT, IDLE, WR, RD, ACK, CSET, CHOLD, CCLR
  } state_t;

  state_t        state, state_n;
  logic          pend, pend_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] d_n, rdata_n;
  logic          wr_n, ack_n;

  assign commit_busy = pend | (state == CSET) | (state == CHOLD) | (state == CCLR);

  // Next state plus next values of every registered output.
  always_comb begin
    state_n = state;
    pend_n  = pend | commit;
    cnt_n   = cnt;
    addr_n  = ram_addr;
    d_n     = ram_d;
    wr_n    = 1'b0;
    ack_n   = 1'b0;
    rdata_n = host_rdata;
    case (state)
      // Clear flags once after reset so the poller never sees a stale set bit.
      INIT: begin
        addr_n  = FLAGS;
        d_n     = '0;
        wr_n    = 1'b1;
        state_n = IDLE;
      end
      // A commit arriving this very cycle is consumed directly; it also beats
      // a simultaneous host request.
      IDLE: begin
        if (pend || commit) begin
          pend_n  = 1'b0;
          addr_n  = FLAGS;
          d_n     = DW'(1);
          wr_n    = 1'b1;
          state_n = CSET;
        end else if (host_req) begin
          addr_n = host_addr;
          cnt_n  = '0;
          if (host_wr) begin
            d_n     = host_wdata;
            wr_n    = 1'b1;
            state_n = WR;
          end else begin
            state_n = RD;
          end
        end
      end
      WR: begin
        ack_n   = 1'b1;
        state_n = ACK;
      end
      // Address went out on accept; q is valid RD_LAT edges later.
      RD: begin
        if (cnt == CW'(RD_LAT)) begin
          rdata_n = ram_q;
          ack_n   = 1'b1;
          state_n = ACK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // req is not sampled here, so a held request cannot be accepted twice.
      ACK: state_n = IDLE;
      CSET: begin
        cnt_n   = CW'(COMMIT_HOLD - 1);
        state_n = CHOLD;
      end
      // Host accesses wait here, so a flags read can never observe bit0=1.
      CHOLD: begin
        if (cnt == '0) begin
          addr_n  = FLAGS;
          d_n     = '0;
          wr_n    = 1'b1;
          state_n = CCLR;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CCLR:    state_n = IDLE;
      default: state_n = INIT;
    endcase
  end

  // State and registered outputs; reset drops everything immediately.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      pend       <= 1'b0;
      cnt        <= '0;
      ram_addr   <= '0;
      ram_d      <= '0;
      ram_wr     <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      state      <= state_n;
      pend       <= pend_n;
      cnt        <= cnt_n;
      ram_addr   <= addr_n;
      ram_d      <= d_n;
      ram_wr     <= wr_n;
      host_ack   <= ack_n;
      host_rdata <= rdata_n;
    end
  end

endmodule

// File: tb/tb_reg_ram_host_bridge.sv
// Randomised bench for reg_ram_host_bridge: behavioural RAM on port A,
// register-file model for expected read data, commit timing from the
// set/hold/clear rules.
module tb_reg_ram_host_bridge;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int RDL  = 1;
  localparam int HOLD = 16;

  logic          c = 1'b0;
  logic          rst = 1'b1;
  logic          host_req = 1'b0;
  logic          host_wr = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          commit = 1'b0;
  logic          commit_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  reg_ram_host_bridge #(
    .AW(AW), .DW(DW), .FLAGS_ADDR(0), .RD_LAT(RDL), .COMMIT_HOLD(HOLD)
  ) dut (
    .c(c), .rst(rst),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .commit(commit), .commit_busy(commit_busy),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 c = ~c;

  // Port-A RAM, one clock read latency.
  logic [DW-1:0] mem [0:255];
  always @(posedge c) begin
    if (ram_wr) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  // Reference register file.
  logic [DW-1:0] ref_mem [0:255];
  bit            ref_vld [0:255];
  logic [DW-1:0] last_rd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One host access started at a negedge; returns at the negedge after the ack pulse.
  task automatic host_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input bit with_commit, input int exp_lat, input int exp_nwr);
    int lat = 0;
    int nwr = 0;
    logic got_ack;
    string t;
    t = wr ? "wr" : "rd";
    host_req = 1'b1; host_wr = wr; host_addr = a; host_wdata = wd;
    commit = with_commit;
    while (lat < 200) begin
      @(posedge c); @(negedge c);
      commit = 1'b0;
      lat++;
      if (ram_wr) nwr++;
      if (host_ack) break;
    end
    got_ack = host_ack;
    host_req = 1'b0;
    chk({t, "_ack"}, got_ack, 1);
    chk({t, "_lat"}, lat, exp_lat);
    chk({t, "_ram_wr_cycles"}, nwr, exp_nwr);
    if (wr) begin
      ref_mem[a] = wd;
      ref_vld[a] = 1'b1;
      chk("rdata_hold", host_rdata, last_rd);
    end else begin
      if (ref_vld[a]) chk("rd_data", host_rdata, ref_mem[a]);
      last_rd = host_rdata;
    end
    @(posedge c); @(negedge c);
    chk({t, "_ack_pulse"}, host_ack, 0);
  endtask

  // Commit trace: pulse commit now (and again at cycle p2 if nonzero), record port-A writes.
  int          wcyc [$];
  logic [DW-1:0] wdat [$];
  logic [AW-1:0] wadr [$];
  int          busy_drop;
  task automatic observe(input int n, input int p2);
    wcyc.delete(); wdat.delete(); wadr.delete();
    busy_drop = -1;
    commit = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(posedge c); @(negedge c);
      commit = (i == p2);
      if (ram_wr) begin
        wcyc.push_back(i); wdat.push_back(ram_d); wadr.push_back(ram_addr);
      end
      if (!commit_busy && busy_drop < 0) busy_drop = i;
    end
  endtask

  // Check one set/clear sequence starting at cycle s in the recorded trace.
  task automatic chk_seq(input string t, input int idx, input int s);
    if (wcyc.size() >= idx + 2) begin
      chk({t, "_set_cyc"}, wcyc[idx], s);
      chk({t, "_set_d"}, wdat[idx], 1);
      chk({t, "_set_addr"}, wadr[idx], 0);
      chk({t, "_clr_cyc"}, wcyc[idx+1], s + HOLD + 1);
      chk({t, "_clr_d"}, wdat[idx+1], 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_vld[i] = 1'b0; end
    last_rd = '0;

    // Reset state
    repeat (3) @(negedge c);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_busy", commit_busy, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_d", ram_d, 0);
    chk("rst_rdata", host_rdata, 0);
    rst = 1'b0;
    @(posedge c); @(negedge c);
    chk("init_wr", ram_wr, 1);
    chk("init_addr", ram_addr, 0);
    chk("init_d", ram_d, 0);
    @(posedge c); @(negedge c);
    chk("init_done_wr", ram_wr, 0);
    chk("init_done_busy", commit_busy, 0);
    ref_mem[0] = '0; ref_vld[0] = 1'b1;

    // Directed write/read of DEADBEEF, then flags read after INIT
    host_op(1, 8'd3, 32'hDEADBEEF, 0, 2, 1);
    host_op(0, 8'd3, '0, 0, RDL + 2, 0);
    host_op(0, 8'd0, '0, 0, RDL + 2, 0);

    // Fill, then random traffic
    for (int a = 1; a < 16; a++) host_op(1, AW'(a), $urandom, 0, 2, 1);
    for (int k = 0; k < 40; k++) begin
      bit w;
      logic [AW-1:0] a;
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 15));
      host_op(w, a, $urandom, 0, w ? 2 : RDL + 2, w ? 1 : 0);
      repeat ($urandom_range(0, 2)) @(negedge c);
    end

    // Single commit pulse in IDLE
    observe(24, 0);
    chk("c1_nwr", wcyc.size(), 2);
    chk_seq("c1", 0, 1);
    chk("c1_busy_drop", busy_drop, HOLD + 3);
    ref_mem[0] = '0;

    // Two commit pulses 5 cycles apart: back-to-back sequences, busy held
    observe(45, 5);
    chk("c2_nwr", wcyc.size(), 4);
    chk_seq("c2a", 0, 1);
    chk_seq("c2b", 2, HOLD + 4);
    chk("c2_busy_drop", busy_drop, 2 * HOLD + 6);

    // Commit and host write in the same cycle: commit runs first
    host_op(1, 8'd5, 32'h12345678, 1, HOLD + 5, 3);
    host_op(0, 8'd5, '0, 0, RDL + 2, 0);

    // Flags read issued during the hold is deferred past the clear
    commit = 1'b1;
    @(posedge c); @(negedge c);
    commit = 1'b0;
    repeat (2) begin @(posedge c); @(negedge c); end
    host_op(0, 8'd0, '0, 0, HOLD + RDL + 2, 1);

    // Reset during the hold
    observe(6, 0);
    chk("rh_busy_before", commit_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rh_ram_wr", ram_wr, 0);
    chk("rh_busy", commit_busy, 0);
    chk("rh_ack", host_ack, 0);
    @(negedge c); @(negedge c);
    rst = 1'b0;
    last_rd = '0;
    @(posedge c); @(negedge c);
    chk("rh_init_wr", ram_wr, 1);
    chk("rh_init_addr", ram_addr, 0);
    chk("rh_init_d", ram_d, 0);
    ref_mem[0] = '0;
    @(posedge c); @(negedge c);
    chk("rh_idle_wr", ram_wr, 0);
    chk("rh_idle_busy", commit_busy, 0);
    host_op(0, 8'd0, '0, 0, RDL + 2, 0);
    host_op(0, 8'd3, '0, 0, RDL + 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
